fetch_stage: RTL and testbench

//   Instruction fetch stage and IF/ID pipeline register of the pipelined core.

---
 rtl/fetch_stage_if.sv | 29 ++
 rtl/fetch_stage.sv | 136 +++++++++++++
 tb/tb_fetch_stage.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//   Instruction-memory bus between the fetch stage and a synchronous
//   instruction memory with one-cycle read latency.
//   Signals:
//     imem_req_o    fetch request this cycle              (fetch -> memory)
//     imem_addr_o   fetch address, valid with imem_req_o  (fetch -> memory)
//     imem_rdata_i  word for last cycle's request          (memory -> fetch)
//   Modports:
//     master  fetch stage side
//     slave   memory side
// -----------------------------------------------------------------------------
interface fetch_stage_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_rdata_i
  );
endinterface

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage plus the IF/ID pipeline register. Holds the PC,
//   issues one request per cycle to a synchronous instruction memory, and
//   presents {valid, instruction, pc, pc+4} to decode. Decode stalls are
//   absorbed by a one-entry skid buffer; redirects flush and refetch.
//   Ports:
//     clk            core clock, rising edge
//     rst_n          asynchronous active-low reset
//     stall_i        hold IF/ID and do not issue a fetch
//     redirect_i     flush and refetch from redirect_pc_i (beats stall_i)
//     redirect_pc_i  redirect target, bits [1:0] forced to zero
//     imem           instruction-memory bus (master side)
//     id_valid_o     IF/ID holds a real instruction
//     id_instr_o     IF/ID instruction (NOP_INSTR on bubbles)
//     id_pc_o        address of id_instr_o
//     id_pc_plus4_o  id_pc_o + 4, registered
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  fetch_stage_if.master      imem,
  output logic               id_valid_o,
  output logic [31:0]        id_instr_o,
  output logic [31:0]        id_pc_o,
  output logic [31:0]        id_pc_plus4_o
);

  logic [31:0] pc_q,          pc_d;
  logic        inflight_q,    inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic        skid_valid_q,  skid_valid_d;
  logic [31:0] skid_instr_q,  skid_instr_d;
  logic [31:0] skid_pc_q,     skid_pc_d;
  logic        id_valid_q,    id_valid_d;
  logic [31:0] id_instr_q,    id_instr_d;
  logic [31:0] id_pc_q,       id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic        req;

  // rst_n gates the request so nothing is issued while reset is held.
  assign req              = rst_n & ~stall_i & ~redirect_i;
  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = pc_q;

  assign id_valid_o    = id_valid_q;
  assign id_instr_o    = id_instr_q;
  assign id_pc_o       = id_pc_q;
  assign id_pc_plus4_o = id_pc_plus4_q;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_instr_d  = skid_instr_q;
    skid_pc_d     = skid_pc_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;

    if (req) begin
      pc_d          = pc_q + 32'd4;
      inflight_d    = 1'b1;
      inflight_pc_d = pc_q;
    end

    if (redirect_i) begin
      // Response currently on the bus belongs to the wrong path: drop it
      // along with anything parked in the skid.
      pc_d         = {redirect_pc_i[31:2], 2'b00};
      skid_valid_d = 1'b0;
      id_valid_d   = 1'b0;
      id_instr_d   = NOP_INSTR;
    end else if (stall_i) begin
      // Memory answers regardless of the stall, so park the response.
      // No request is issued while stalled, so the skid cannot overflow.
      if (inflight_q) begin
        skid_valid_d = 1'b1;
        skid_instr_d = imem.imem_rdata_i;
        skid_pc_d    = inflight_pc_q;
      end
    end else begin
      if (skid_valid_q) begin
        skid_valid_d  = 1'b0;
        id_valid_d    = 1'b1;
        id_instr_d    = skid_instr_q;
        id_pc_d       = skid_pc_q;
        id_pc_plus4_d = skid_pc_q + 32'd4;
      end else if (inflight_q) begin
        id_valid_d    = 1'b1;
        id_instr_d    = imem.imem_rdata_i;
        id_pc_d       = inflight_pc_q;
        id_pc_plus4_d = inflight_pc_q + 32'd4;
      end else begin
        // Bubble: pc fields keep their last value.
        id_valid_d = 1'b0;
        id_instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'd0;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= 32'd0;
      skid_pc_q     <= 32'd0;
      id_valid_q    <= 1'b0;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd4;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc_q     <= skid_pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Scoreboard bench for fetch_stage. The stimulus process drives one cycle at
//   a time and pushes the expected fetch request and IF/ID contents computed
//   from an in-order queue model of outstanding fetches. A monitor pops and
//   compares independently. Reset checks are made directly while rst_n is low.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] rpc = 32'd0;
  logic        id_valid;
  logic [31:0] id_instr, id_pc, id_pc_plus4;

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (rpc),
    .imem          (imem),
    .id_valid_o    (id_valid),
    .id_instr_o    (id_instr),
    .id_pc_o       (id_pc),
    .id_pc_plus4_o (id_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // Synchronous memory: answers last cycle's request, garbage otherwise.
  always @(posedge clk) begin
    if (imem.imem_req_o) imem.imem_rdata_i <= mem_word(imem.imem_addr_o);
    else                 imem.imem_rdata_i <= $urandom;
  end

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] p4;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model: program-order queue of issued-but-undelivered fetches.
  logic [31:0] m_pc;
  logic [31:0] pend[$];
  logic        m_v;
  logic [31:0] m_instr, m_idpc, m_p4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req_v);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    m_pc    = RESET_PC;
    m_v     = 1'b0;
    m_instr = NOP;
    m_idpc  = 32'd0;
    m_p4    = 32'd4;
  endtask

  // Called at posedge+2; returns at the next posedge+2.
  task automatic do_cycle(input logic s, input logic r, input logic [31:0] t);
    exp_t        e;
    logic [31:0] a;
    stall    = s;
    redirect = r;
    rpc      = t;
    e.req    = !s && !r;
    e.addr   = m_pc;
    if (r) begin
      pend.delete();
      m_pc    = t & 32'hFFFF_FFFC;
      m_v     = 1'b0;
      m_instr = NOP;
    end else if (!s) begin
      if (pend.size() > 0) begin
        a       = pend.pop_front();
        m_v     = 1'b1;
        m_instr = mem_word(a);
        m_idpc  = a;
        m_p4    = a + 32'd4;
      end else begin
        m_v     = 1'b0;
        m_instr = NOP;
      end
      pend.push_back(m_pc);
      m_pc = m_pc + 32'd4;
    end
    e.v = m_v; e.instr = m_instr; e.pc = m_idpc; e.p4 = m_p4;
    sb.push_back(e);
    $display("cycle stall=%0d redirect=%0d target=%h exp_req=%0d exp_addr=%h -> v=%0d pc=%h",
             s, r, t, e.req, e.addr, e.v, e.pc);
    @(posedge clk);
    #2;
  endtask

  // Assert reset away from the edge, check async clear, release later.
  task automatic pulse_reset();
    stall = 1'b0; redirect = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, NOP);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_pc4", id_pc_plus4, 32'd4);
    chk("rst_req", {31'd0, imem.imem_req_o}, 32'd0);
    chk("rst_addr", imem.imem_addr_o, RESET_PC);
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    $display("reset pulse done");
  endtask

  // Monitor: request checked mid-cycle, IF/ID checked just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb[0];
        chk("req", {31'd0, imem.imem_req_o}, {31'd0, e.req});
        if (e.req) chk("addr", imem.imem_addr_o, e.addr);
        @(posedge clk);
        #1;
        chk("id_valid", {31'd0, id_valid}, {31'd0, e.v});
        chk("id_instr", id_instr, e.instr);
        chk("id_pc", id_pc, e.pc);
        chk("id_pc4", id_pc_plus4, e.p4);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    int n;
    model_reset();
    @(posedge clk);
    #2;
    pulse_reset();

    // Straight-line fetch 0,4,8 then a 3-cycle stall while 0x8 is in flight.
    repeat (3) do_cycle(1'b0, 1'b0, 32'd0);
    repeat (3) do_cycle(1'b1, 1'b0, 32'd0);
    repeat (2) do_cycle(1'b0, 1'b0, 32'd0);
    // Redirect while 0x10 is in flight.
    do_cycle(1'b0, 1'b1, 32'h0000_0100);
    repeat (4) do_cycle(1'b0, 1'b0, 32'd0);
    // Skid filled, then stall+redirect to an unaligned target.
    do_cycle(1'b1, 1'b0, 32'd0);
    do_cycle(1'b1, 1'b1, 32'h0000_0203);
    repeat (3) do_cycle(1'b0, 1'b0, 32'd0);
    // Wrap at the top of the address space.
    do_cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    repeat (4) do_cycle(1'b0, 1'b0, 32'd0);
    // Reset with the skid full.
    repeat (2) do_cycle(1'b0, 1'b0, 32'd0);
    do_cycle(1'b1, 1'b0, 32'd0);
    pulse_reset();
    repeat (3) do_cycle(1'b0, 1'b0, 32'd0);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      logic        s, r;
      logic [31:0] t;
      n = $urandom_range(0, 99);
      s = (n < 30);
      r = ($urandom_range(0, 99) < 10);
      t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
      if (i == 250 || i == 480) pulse_reset();
      do_cycle(s, r, t);
    end
    stall = 1'b0; redirect = 1'b0;

    n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    #3;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
